// File: rtl/dec_key_entry_ctrl.sv
// Debounced decimal keypad entry: collects NDIGITS BCD digits, then offers them on a valid/ready handshake.
// Outputs are registered; a full entry is held stable on out_bcd until out_ready is seen with out_valid.
module dec_key_entry_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NDIGITS         = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [9:0]             key_in,
    input  logic                   clear,
    input  logic                   out_ready,
    output logic                   out_valid,
    output logic [4*NDIGITS-1:0]   out_bcd,
    output logic [2:0]             digit_count,
    output logic                   key_error,
    output logic                   busy
);

    typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, EMIT} state_t;

    localparam logic [7:0] DB_LAST = 8'(DEBOUNCE_CYCLES);
    localparam logic [2:0] NDIG    = 3'(NDIGITS);

    state_t                 state, state_nxt;
    logic [9:0]             cand, cand_nxt;
    logic [7:0]             cnt, cnt_nxt;
    logic [4*NDIGITS-1:0]   bcd_nxt;
    logic [2:0]             dcnt_nxt;
    logic                   valid_nxt;
    logic                   err_nxt;
    logic                   one_hot;
    logic [3:0]             key_idx;

    // Candidate decode: exactly one key line set means a legal digit.
    always_comb begin
        key_idx = 4'd0;
        for (int k = 0; k < 10; k++) begin
            if (cand[k]) key_idx = 4'(k);
        end
        one_hot = (cand != 10'd0) && ((cand & (cand - 10'd1)) == 10'd0);
    end

    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        cnt_nxt   = cnt;
        bcd_nxt   = out_bcd;
        dcnt_nxt  = digit_count;
        valid_nxt = out_valid;
        err_nxt   = 1'b0;

        if (clear) begin
            state_nxt = IDLE;
            cand_nxt  = 10'd0;
            cnt_nxt   = 8'd0;
            bcd_nxt   = '0;
            dcnt_nxt  = 3'd0;
            valid_nxt = 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_in != 10'd0) begin
                        cand_nxt  = key_in;
                        cnt_nxt   = 8'd1;
                        state_nxt = DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (key_in != cand) begin
                        cnt_nxt   = 8'd0;
                        state_nxt = IDLE;
                    end else if (cnt + 8'd1 == DB_LAST) begin
                        if (one_hot) begin
                            bcd_nxt      = out_bcd << 4;
                            bcd_nxt[3:0] = key_idx;
                            dcnt_nxt     = digit_count + 3'd1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                        cnt_nxt   = 8'd0;
                        state_nxt = HOLD;
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                HOLD: begin
                    // Any bounce back to a pressed level restarts the release count.
                    if (key_in != 10'd0) begin
                        cnt_nxt = 8'd0;
                    end else if (cnt + 8'd1 == DB_LAST) begin
                        cnt_nxt = 8'd0;
                        if (digit_count == NDIG) begin
                            state_nxt = EMIT;
                            valid_nxt = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt + 8'd1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        valid_nxt = 1'b0;
                        bcd_nxt   = '0;
                        dcnt_nxt  = 3'd0;
                        state_nxt = IDLE;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cand        <= 10'd0;
            cnt         <= 8'd0;
            out_bcd     <= '0;
            digit_count <= 3'd0;
            out_valid   <= 1'b0;
            key_error   <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            cand        <= cand_nxt;
            cnt         <= cnt_nxt;
            out_bcd     <= bcd_nxt;
            digit_count <= dcnt_nxt;
            out_valid   <= valid_nxt;
            key_error   <= err_nxt;
            busy        <= (state_nxt != IDLE);
        end
    end

endmodule
